// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: opcodes, FSM encodings, status bit indices and decode struct for the ALU sequencer.
// ALU_OP_SEQUENCER_CMP_EN makes opcode 101 (CMP) a legal ALU op.
package alu_op_sequencer_pkg;
  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_CMP = 3'd5;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam int ST_Z = 0;
  localparam int ST_C = 1;
  localparam int ST_N = 2;
  localparam int ST_V = 3;
  typedef struct packed {
    logic addsub;
    logic add_ctrl;
    logic xor_ctrl;
    logic mul_out_ctrl;
    logic acc_enable;
    logic upd_status;
    logic illegal;
  } dec_t;
  // true for opcodes that go through LOAD/EXEC
  function automatic logic op_runs_alu(input logic [2:0] op);
`ifdef ALU_OP_SEQUENCER_CMP_EN
    return op >= OP_ADD && op <= OP_CMP;
`else
    return op >= OP_ADD && op <= OP_MUL;
`endif
  endfunction
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: registered opcode plus EXEC flag -> ALU control strobes, status update and illegal flag.
// ALU_OP_SEQUENCER_CMP_EN enables the CMP opcode decode.
module alu_op_decoder
  import alu_op_sequencer_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic [OP_W-1:0] op,
  input  logic            exec,
  output dec_t            dec
);
  logic [2:0] op3;
  logic is_add, is_sub, is_xor, is_mul, is_cmp;
  assign op3    = 3'(op);
  assign is_add = op3 == OP_ADD;
  assign is_sub = op3 == OP_SUB;
  assign is_xor = op3 == OP_XOR;
  assign is_mul = op3 == OP_MUL;
`ifdef ALU_OP_SEQUENCER_CMP_EN
  assign is_cmp = op3 == OP_CMP;
`else
  assign is_cmp = 1'b0;
`endif
  always_comb begin
    dec.addsub       = exec & (is_sub | is_cmp);
    dec.add_ctrl     = exec & (is_add | is_sub);
    dec.xor_ctrl     = exec & is_xor;
    dec.mul_out_ctrl = exec & is_mul;
    dec.acc_enable   = exec & (is_add | is_sub | is_xor | is_mul);
    dec.upd_status   = exec & (is_add | is_sub | is_cmp);
    dec.illegal      = (op3 != OP_NOP) & ~op_runs_alu(op3);
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready command front end sequencing ALU strobes IDLE->LOAD->EXEC->DONE.
// ALU_OP_SEQUENCER_CMP_EN enables opcode 101 as CMP (subtract for flags only).
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              a_enable,
  output logic              addsub,
  output logic              add_ctrl,
  output logic              xor_ctrl,
  output logic              mul_out_ctrl,
  output logic              acc_enable,
  input  logic [DATA_W-1:0] acc_out,
  input  logic [DATA_W-1:0] mul_acc_out,
  input  logic [3:0]        status_reg,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] rsp_data_hi,
  output logic [3:0]        rsp_status,
  output logic              rsp_err
);
  logic [1:0]        state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]        status_q, status_d;
  dec_t              dec;

  alu_op_decoder #(.OP_W(OP_W)) u_dec (
    .op  (op_q),
    .exec(state_q == S_EXEC),
    .dec (dec)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    status_d = dec.upd_status ? status_reg : status_q;
    if (state_q == S_IDLE && cmd_valid) begin
      op_d    = cmd_op;
      a_d     = cmd_a;
      b_d     = cmd_b;
      state_d = op_runs_alu(3'(cmd_op)) ? S_LOAD : S_DONE;
    end else if (state_q == S_LOAD) begin
      state_d = S_EXEC;
    end else if (state_q == S_EXEC) begin
      state_d = S_DONE;
    end else if (state_q == S_DONE && rsp_ready) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      status_q <= status_d;
    end
  end

  // strobes are pure decodes of state, so an async reset drops them immediately
  assign cmd_ready    = state_q == S_IDLE;
  assign a_enable     = state_q == S_LOAD;
  assign addsub       = dec.addsub;
  assign add_ctrl     = dec.add_ctrl;
  assign xor_ctrl     = dec.xor_ctrl;
  assign mul_out_ctrl = dec.mul_out_ctrl;
  assign acc_enable   = dec.acc_enable;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign rsp_valid    = state_q == S_DONE;
  assign rsp_data     = rsp_valid ? acc_out : '0;
  assign rsp_data_hi  = rsp_valid ? mul_acc_out : '0;
  assign rsp_status   = status_q;
  assign rsp_err      = rsp_valid & dec.illegal;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of the ALU sequencer against a small behavioural ALU/accumulator.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam logic [31:0] SB_LOAD = 32'h20;
  localparam logic [31:0] SB_ADD  = 32'h09;
  localparam logic [31:0] SB_SUB  = 32'h19;
  localparam logic [31:0] SB_XOR  = 32'h05;
  localparam logic [31:0] SB_MUL  = 32'h03;
  localparam logic [31:0] SB_CMP  = 32'h10;
`ifdef ALU_OP_SEQUENCER_CMP_EN
  localparam logic [31:0] ST_LAST = 32'h3;
`else
  localparam logic [31:0] ST_LAST = 32'h4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready, rsp_ready, rsp_valid, rsp_err;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b, alu_a, alu_b, rsp_data, rsp_data_hi;
  logic        a_enable, addsub, add_ctrl, xor_ctrl, mul_out_ctrl, acc_enable;
  logic [3:0]  status_reg, rsp_status;
  logic [5:0]  strb;
  int          checks = 0;
  int          errors = 0;

  logic [15:0] a_reg = '0;
  logic [15:0] acc = '0;
  logic [15:0] mul_acc = '0;
  logic [15:0] bb;
  logic [16:0] sum;
  logic [31:0] prod;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_a(alu_a), .alu_b(alu_b), .a_enable(a_enable),
    .addsub(addsub), .add_ctrl(add_ctrl), .xor_ctrl(xor_ctrl), .mul_out_ctrl(mul_out_ctrl),
    .acc_enable(acc_enable), .acc_out(acc), .mul_acc_out(mul_acc), .status_reg(status_reg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_data_hi(rsp_data_hi), .rsp_status(rsp_status), .rsp_err(rsp_err)
  );

  // behavioural ALU: A register, adder with flags, xor, multiplier, accumulators
  assign strb = {a_enable, addsub, add_ctrl, xor_ctrl, mul_out_ctrl, acc_enable};
  assign bb   = addsub ? ~alu_b : alu_b;
  assign sum  = {1'b0, a_reg} + {1'b0, bb} + 17'(addsub);
  assign prod = {16'b0, a_reg} * {16'b0, alu_b};
  always_comb begin
    status_reg       = '0;
    status_reg[ST_Z] = sum[15:0] == 16'h0;
    status_reg[ST_C] = sum[16];
    status_reg[ST_N] = sum[15];
    status_reg[ST_V] = (a_reg[15] == bb[15]) && (sum[15] != a_reg[15]);
  end
  always @(posedge clk) begin
    if (a_enable) a_reg <= alu_a;
    if (acc_enable) begin
      acc     <= add_ctrl ? sum[15:0] : xor_ctrl ? (a_reg ^ alu_b) : mul_out_ctrl ? prod[15:0] : acc;
      mul_acc <= prod[31:16];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_alu(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] exec_sb,
                         input logic [31:0] exp_data, input logic [31:0] exp_st,
                         input logic [31:0] exp_hi);
    send(op, a, b);
    chk({tag, "_load_strb"}, 32'(strb), SB_LOAD);
    chk({tag, "_load_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_alu_ab"}, {alu_a, alu_b}, {a, b});
    tick();
    chk({tag, "_exec_strb"}, 32'(strb), exec_sb);
    chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_done_strb"}, 32'(strb), 32'd0);
    chk({tag, "_done_data"}, 32'(rsp_data), exp_data);
    chk({tag, "_done_hi"}, 32'(rsp_data_hi), exp_hi);
    chk({tag, "_done_status"}, 32'(rsp_status), exp_st);
    chk({tag, "_done_err"}, 32'(rsp_err), 32'd0);
    if (rsp_ready) begin
      tick();
      chk({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic run_short(input string tag, input logic [2:0] op, input logic [31:0] exp_err,
                           input logic [31:0] exp_data, input logic [31:0] exp_st);
    send(op, 16'h1234, 16'h5678);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_err"}, 32'(rsp_err), exp_err);
    chk({tag, "_strb"}, 32'(strb), 32'd0);
    chk({tag, "_data"}, 32'(rsp_data), exp_data);
    chk({tag, "_status"}, 32'(rsp_status), exp_st);
    tick();
    chk({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_idle_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_idle_strb"}, 32'(strb), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strb", 32'(strb), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_ab", {alu_a, alu_b}, 32'd0);
    chk("rst_status", 32'(rsp_status), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    rst = 1'b1;
    tick();
    chk("rst_ready", 32'(cmd_ready), 32'd1);

    run_alu("add", OP_ADD, 16'd3, 16'd5, SB_ADD, 32'd8, 32'h0, 32'h0);
    run_alu("sub", OP_SUB, 16'd5, 16'd7, SB_SUB, 32'hFFFE, 32'h4, 32'h0);
    run_alu("mul", OP_MUL, 16'h0100, 16'h0100, SB_MUL, 32'h0, 32'h4, 32'h1);
    run_alu("xor", OP_XOR, 16'hF0F0, 16'h0FF0, SB_XOR, 32'hFF00, 32'h4, 32'h0EFF);
    run_short("ill7", 3'b111, 32'd1, 32'hFF00, 32'h4);
`ifdef ALU_OP_SEQUENCER_CMP_EN
    run_alu("cmp", OP_CMP, 16'd4, 16'd4, SB_CMP, 32'hFF00, 32'h3, 32'h0EFF);
`else
    run_short("ill5", OP_CMP, 32'd1, 32'hFF00, 32'h4);
`endif
    run_short("nop", OP_NOP, 32'd0, 32'hFF00, ST_LAST);

    rsp_ready = 1'b0;
    run_alu("bp", OP_ADD, 16'd1, 16'd1, SB_ADD, 32'd2, 32'h0, 32'h0);
    cmd_valid = 1'b1;
    cmd_op    = OP_SUB;
    cmd_a     = 16'd9;
    cmd_b     = 16'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_data", 32'(rsp_data), 32'd2);
      chk("bp_hold_ready", 32'(cmd_ready), 32'd0);
      chk("bp_hold_strb", 32'(strb), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("bp_no_accept_ready", 32'(cmd_ready), 32'd1);
    chk("bp_no_accept_strb", 32'(strb), 32'd0);
    chk("bp_acc", 32'(acc), 32'd2);

    send(OP_ADD, 16'd10, 16'd20);
    tick();
    chk("rstx_exec_strb", 32'(strb), SB_ADD);
    #1 rst = 1'b0;
    #1;
    chk("rstx_strb_drop", 32'(strb), 32'd0);
    chk("rstx_valid", 32'(rsp_valid), 32'd0);
    chk("rstx_ab", {alu_a, alu_b}, 32'd0);
    tick();
    chk("rstx_acc", 32'(acc), 32'd2);
    rst = 1'b1;
    tick();
    chk("rstx_ready", 32'(cmd_ready), 32'd1);
    chk("rstx_status", 32'(rsp_status), 32'd0);
    run_alu("post", OP_ADD, 16'd1, 16'd2, SB_ADD, 32'd3, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
